// File: rtl/lc3_data_mem_ctrl.sv
// LC3 data-memory controller: one load/store at a time, fixed LATENCY, single-cycle completion strobe.
// Word-addressed 16-bit array of depth 2^ADDR_W; upper address bits alias. Contents survive reset.
module lc3_data_mem_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        Data_en,
  input  logic        Data_rd,
  input  logic [15:0] Data_addr,
  input  logic [15:0] Data_din,
  output logic [15:0] Data_dout,
  output logic        complete_data,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [3:0]          r_cnt;
  logic                r_rd;
  logic [ADDR_W-1:0]   r_idx;
  logic [15:0]         r_din;
  logic [15:0]         r_dout;
  logic [15:0]         r_rd_count;
  logic [15:0]         r_wr_count;
  logic [15:0]         r_mem [0:(1<<ADDR_W)-1];

  logic                w_accept;
  logic                w_enter_done;
  logic                w_op_rd;
  logic [ADDR_W-1:0]   w_op_idx;
  logic [15:0]         w_op_din;
  logic                w_mem_we;
  logic                w_mem_re;
  logic                w_complete;
  logic                w_busy;
  logic                w_unused_addr_hi;

  assign w_unused_addr_hi = ^Data_addr[15:ADDR_W];
  assign w_accept         = (r_state == S_IDLE) && Data_en;
  assign w_enter_done     = (w_state_nxt == S_DONE) && (r_state != S_DONE);

  // With LATENCY==1 the DONE entry edge is the accept edge, so the access uses the live inputs.
  assign w_op_rd  = (r_state == S_IDLE) ? Data_rd                  : r_rd;
  assign w_op_idx = (r_state == S_IDLE) ? Data_addr[ADDR_W-1:0]    : r_idx;
  assign w_op_din = (r_state == S_IDLE) ? Data_din                 : r_din;

  assign w_mem_we = w_enter_done && !w_op_rd && !reset;
  assign w_mem_re = w_enter_done &&  w_op_rd;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (Data_en) begin
          w_state_nxt = (LATENCY == 1) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_complete = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_WAIT: w_busy = 1'b1;
      S_DONE: begin
        w_busy     = 1'b1;
        w_complete = 1'b1;
      end
      default: begin
        w_busy     = 1'b0;
        w_complete = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt <= 4'd0;
      r_rd  <= 1'b0;
      r_idx <= '0;
      r_din <= 16'h0000;
    end else if (w_accept) begin
      r_cnt <= LAT_M1;
      r_rd  <= Data_rd;
      r_idx <= Data_addr[ADDR_W-1:0];
      r_din <= Data_din;
    end else if (r_state == S_WAIT) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dout <= 16'h0000;
    end else if (w_mem_re) begin
      r_dout <= r_mem[w_op_idx];
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_mem[w_op_idx] <= w_op_din;
    end
  end

  // Counters advance on the edge that leaves DONE and stick at all-ones.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_count <= 16'h0000;
      r_wr_count <= 16'h0000;
    end else if (r_state == S_DONE) begin
      if (r_rd && (r_rd_count != 16'hFFFF)) begin
        r_rd_count <= r_rd_count + 16'd1;
      end
      if (!r_rd && (r_wr_count != 16'hFFFF)) begin
        r_wr_count <= r_wr_count + 16'd1;
      end
    end
  end

  assign Data_dout     = r_dout;
  assign complete_data = w_complete;
  assign busy          = w_busy;
  assign rd_count      = r_rd_count;
  assign wr_count      = r_wr_count;

endmodule

// File: tb/tb_lc3_data_mem_ctrl.sv
// Directed bench for lc3_data_mem_ctrl (LATENCY=2, ADDR_W=10): vector table plus multi-cycle corner sequences.
module tb_lc3_data_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        Data_en = 1'b0;
  logic        Data_rd = 1'b0;
  logic [15:0] Data_addr = 16'h0000;
  logic [15:0] Data_din = 16'h0000;
  logic [15:0] Data_dout;
  logic        complete_data;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int n_tests = 0;
  int n_fail  = 0;

  lc3_data_mem_ctrl #(.ADDR_W(10), .LATENCY(2)) dut (
    .clock         (clock),
    .reset         (reset),
    .Data_en       (Data_en),
    .Data_rd       (Data_rd),
    .Data_addr     (Data_addr),
    .Data_din      (Data_din),
    .Data_dout     (Data_dout),
    .complete_data (complete_data),
    .busy          (busy),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic [15:0] exp_rdc;
    logic [15:0] exp_wrc;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "/dout"},     Data_dout,             16'h0000);
    check({tag, "/complete"}, {15'd0, complete_data}, 16'h0000);
    check({tag, "/busy"},     {15'd0, busy},          16'h0000);
    check({tag, "/rd_count"}, rd_count,              16'h0000);
    check({tag, "/wr_count"}, wr_count,              16'h0000);
  endtask

  // One request from IDLE; inputs are scrambled right after the accept edge.
  task automatic do_req(input string tag, input logic rd, input logic [15:0] addr,
                        input logic [15:0] din, input logic [15:0] exp_dout,
                        input logic [15:0] exp_rdc, input logic [15:0] exp_wrc);
    @(negedge clock);
    Data_en   = 1'b1;
    Data_rd   = rd;
    Data_addr = addr;
    Data_din  = din;
    @(posedge clock);
    #1;
    Data_en   = 1'b0;
    Data_rd   = ~rd;
    Data_addr = ~addr;
    Data_din  = ~din;
    check({tag, "/E0 busy"},     {15'd0, busy},          16'h0001);
    check({tag, "/E0 complete"}, {15'd0, complete_data}, 16'h0000);
    @(posedge clock);
    #1;
    check({tag, "/E1 complete"}, {15'd0, complete_data}, 16'h0001);
    check({tag, "/E1 dout"},     Data_dout,              exp_dout);
    @(posedge clock);
    #1;
    check({tag, "/E2 complete"}, {15'd0, complete_data}, 16'h0000);
    check({tag, "/E2 busy"},     {15'd0, busy},          16'h0000);
    check({tag, "/E2 rd_count"}, rd_count,               exp_rdc);
    check({tag, "/E2 wr_count"}, wr_count,               exp_wrc);
  endtask

  initial begin
    int pulses;

    vecs[0] = '{1'b0, 16'h0012, 16'hBEEF, 16'h0000, 16'd0, 16'd1};
    vecs[1] = '{1'b1, 16'h0012, 16'h0000, 16'hBEEF, 16'd1, 16'd1};
    vecs[2] = '{1'b0, 16'h0405, 16'h1234, 16'hBEEF, 16'd1, 16'd2};
    vecs[3] = '{1'b1, 16'h0005, 16'h0000, 16'h1234, 16'd2, 16'd2};
    vecs[4] = '{1'b0, 16'h03FF, 16'hCAFE, 16'h1234, 16'd2, 16'd3};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h0000, 16'hCAFE, 16'd3, 16'd3};
    vecs[6] = '{1'b1, 16'h0012, 16'h0000, 16'hBEEF, 16'd4, 16'd3};
    vecs[7] = '{1'b0, 16'h0001, 16'h0101, 16'hBEEF, 16'd4, 16'd4};
    vecs[8] = '{1'b0, 16'h0020, 16'h5555, 16'hBEEF, 16'd4, 16'd5};

    #12;
    check_all_zero("por");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].din,
             vecs[i].exp_dout, vecs[i].exp_rdc, vecs[i].exp_wrc);
    end

    // Data_en held high: accept every third edge, one pulse per accept.
    pulses = 0;
    @(negedge clock);
    Data_en   = 1'b1;
    Data_rd   = 1'b1;
    Data_addr = 16'h0001;
    for (int k = 0; k < 12; k++) begin
      @(posedge clock);
      #1;
      if (complete_data) pulses++;
      check($sformatf("hold k%0d complete", k), {15'd0, complete_data},
            (k % 3 == 1) ? 16'h0001 : 16'h0000);
      check($sformatf("hold k%0d busy", k), {15'd0, busy},
            (k % 3 == 2) ? 16'h0000 : 16'h0001);
    end
    @(negedge clock);
    Data_en = 1'b0;
    check("hold pulses",   16'(pulses), 16'd4);
    check("hold dout",     Data_dout,   16'h0101);
    check("hold rd_count", rd_count,    16'd8);

    // Asynchronous reset mid-cycle with non-zero outputs.
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async rst");
    @(negedge clock);
    reset = 1'b0;

    // Reset during WAIT abandons the store.
    @(negedge clock);
    Data_en   = 1'b1;
    Data_rd   = 1'b0;
    Data_addr = 16'h0020;
    Data_din  = 16'hAAAA;
    @(posedge clock);
    #1;
    Data_en = 1'b0;
    check("wait rst/busy before", {15'd0, busy}, 16'h0001);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("wait rst/busy",     {15'd0, busy},          16'h0000);
    check("wait rst/complete", {15'd0, complete_data}, 16'h0000);
    @(posedge clock);
    #1;
    check("wait rst/complete E1", {15'd0, complete_data}, 16'h0000);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("wait rst/complete E2", {15'd0, complete_data}, 16'h0000);
    check("wait rst/wr_count",    wr_count,               16'd0);
    do_req("wait rst load", 1'b1, 16'h0020, 16'h0000, 16'h5555, 16'd1, 16'd0);

    // Saturation: preload the load counter near its ceiling.
    @(negedge clock);
    force dut.r_rd_count = 16'hFFFE;
    #1;
    release dut.r_rd_count;
    do_req("sat1", 1'b1, 16'h0012, 16'h0000, 16'hBEEF, 16'hFFFF, 16'd0);
    do_req("sat2", 1'b1, 16'h0005, 16'h0000, 16'h1234, 16'hFFFF, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lc3_data_mem_ctrl.md
# lc3_data_mem_ctrl

Synthesizable data-memory controller that services the LC3 MemAccess stage over the data_mem bus. It accepts one load or store request at a time, waits a fixed access latency, and then returns read data with a single-cycle `complete_data` strobe. It drives the same bus signals that the data_mem monitor samples. It replaces the behavioural data memory in RTL-level regressions.

## Interface
Parameters:
- `ADDR_W`, default 10: number of address bits that index the word array (depth = 2^ADDR_W, 16-bit words).
- `LATENCY`, default 2: cycles from request accept to the `complete_data` cycle. Legal range 1..15.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `Data_en`  in  1  request valid from MemAccess; sampled only in IDLE.
- `Data_rd`  in  1  1 = load, 0 = store; sampled with `Data_en`.
- `Data_addr`  in  16  word address; sampled with `Data_en`.
- `Data_din`  in  16  store data; sampled with `Data_en`.
- `Data_dout`  out  16  load data; registered.
- `complete_data`  out  1  one-cycle completion strobe for loads and stores.
- `busy`  out  1  high while a request is outstanding (WAIT or DONE).
- `rd_count`  out  16  completed loads; saturating.
- `wr_count`  out  16  completed stores; saturating.

## Operation
- FSM states are IDLE, WAIT and DONE. Encoding is free.
- **IDLE**
  - On `Data_en`=1, latch `Data_rd`, `Data_addr[ADDR_W-1:0]` and `Data_din`, and load the latency counter with `LATENCY-1`.
  - If `LATENCY`==1, go to DONE. Otherwise go to WAIT.
  - On `Data_en`=0, stay in IDLE.
- **WAIT**
  - Decrement the counter each cycle.
  - When the counter is 1, the next state is DONE.
  - `Data_en` is ignored.
- **Transition into DONE**
  - Load: `Data_dout` <= mem[latched index].
  - Store: mem[latched index] <= latched din.
- **DONE**
  - `complete_data`=1 for exactly this cycle.
  - Increment `rd_count` or `wr_count`; both saturate at 0xFFFF.
  - Always return to IDLE.
  - `Data_en` in the DONE cycle is ignored. It is accepted on the following IDLE cycle.
- `busy` = (state != IDLE).
- `Data_dout` holds its value until the next load completes. Stores do not change `Data_dout`.
- Address aliasing: bits `[15:ADDR_W]` are ignored. For example, 0x0405 and 0x0005 hit the same word when `ADDR_W`=10.
- Inputs may change freely after the accept edge; only latched copies are used.
- Reset
  - Asynchronously forces state IDLE, counter 0, `Data_dout`=0x0000, `complete_data`=0, `busy`=0, `rd_count`=0, `wr_count`=0.
  - The memory array is not reset. Contents survive reset.
- Reset during WAIT: the request is abandoned. A pending store is not committed and no `complete_data` occurs.
- Reset during DONE: the store was already committed on the DONE entry edge, and `complete_data` drops immediately.

## Timing
- Accept edge E0: `Data_en`=1 while in IDLE. `busy` is high from E0.
- `complete_data` is high in the cycle after edge E0+`LATENCY`-1, i.e. it is sampled high at edge E0+`LATENCY`. For `LATENCY`=2: accept at E0, complete sampled at E2.
- `Data_dout` is valid in the same cycle as `complete_data`.
- `busy` returns to 0 on edge E0+`LATENCY`. The earliest next accept is at that edge.
- Minimum request period is `LATENCY`+1 cycles.
- Back-to-back store-then-load to the same address returns the new data, because the store commits before the load is accepted.
- No combinational path from any input to any output.

## Test plan
All scenarios use `LATENCY`=2 and `ADDR_W`=10.
- Reset values: assert `reset` mid-cycle with no clock edge -> all outputs are 0 immediately; counters are 0x0000.
- Store/load: store 0xBEEF at 0x0012, then load 0x0012.
  - `complete_data` is sampled high 2 edges after each accept.
  - The load returns `Data_dout`=0xBEEF.
  - `wr_count`=1 and `rd_count`=1.
- Aliasing: store 0x1234 at 0x0405, then load 0x0005 -> `Data_dout`=0x1234.
- Busy ignore: hold `Data_en`=1 continuously with loads to 0x0001 -> accepts happen every 3 cycles, and exactly one `complete_data` pulse per accept.
- Reset in WAIT: store 0xAAAA at 0x0020 (memory previously 0x5555), assert `reset` in the WAIT cycle, then load 0x0020.
  - No `complete_data` for the aborted store.
  - The load returns 0x5555.
  - `wr_count`=0.
- Saturation: force 65537 loads (or preload the counter through a bench hook) -> `rd_count` stays at 0xFFFF.
